// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller with a programmable Mealy pattern detector.
// Counts pattern matches per accepted word and pulses done after the last bit.
module seq_scan_ctrl #(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 8,
    parameter int CNT_W  = 5,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              match,
    output logic              done,
    output logic [CNT_W-1:0]  match_count
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);
    localparam logic [PAT_W:0] ONE = 1;
    localparam logic [LEN_W:0] LONE = 1;
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(5);
    localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(3);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  pat;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  fill;
    logic              ovl;
    logic [PAT_W:0]    window;
    logic [PAT_W:0]    mask;
    logic              cfg_ok;
    logic              accept;

    assign accept  = in_valid && in_ready;
    assign cfg_ok  = (cfg_len != '0) && (cfg_len <= FILL_MAX);
    assign bit_out = bit_valid & word[idx];

    // Window bit k is the bit seen k cycles ago; compare only the low len bits.
    assign window = {hist, bit_out};
    assign mask   = (ONE << len) - ONE;
    assign match  = bit_valid
                 && ((window & mask) == ({1'b0, pat} & mask))
                 && (({1'b0, fill} + LONE) >= {1'b0, len});

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            bit_valid   <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            word        <= '0;
            idx         <= '0;
            hist        <= '0;
            fill        <= '0;
            pat         <= PAT_RST;
            len         <= LEN_RST;
            ovl         <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_we && cfg_ok) begin
                        pat <= cfg_pattern;
                        len <= cfg_len;
                        ovl <= cfg_overlap;
                    end
                    if (accept) begin
                        state       <= SCAN;
                        word        <= in_data;
                        idx         <= IDX_MAX;
                        hist        <= '0;
                        fill        <= '0;
                        match_count <= '0;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        bit_valid   <= 1'b1;
                    end
                end
                SCAN: begin
                    hist <= window[PAT_W-1:0];
                    if (match && !ovl) begin
                        fill <= '0;
                    end else if (fill != FILL_MAX) begin
                        fill <= fill + 1'b1;
                    end
                    if (match && (match_count != '1)) begin
                        match_count <= match_count + 1'b1;
                    end
                    if (idx == '0) begin
                        state     <= DONE;
                        bit_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: driver pushes model results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_scan_ctrl;

    localparam int DW = 16;
    localparam int PW = 8;
    localparam int CW = 3;
    localparam int LW = $clog2(PW + 1);

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [PW-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          busy;
    logic          bit_valid;
    logic          bit_out;
    logic          match;
    logic          done;
    logic [CW-1:0] match_count;

    always #5 clk = ~clk;

    seq_scan_ctrl #(
        .DATA_W(DW),
        .PAT_W (PW),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .busy       (busy),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .match      (match),
        .done       (done),
        .match_count(match_count)
    );

    typedef struct {
        logic [DW-1:0] w;
        logic [DW-1:0] mv;
        int            cnt;
        int            acc;
    } exp_t;

    exp_t          q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            held = 0;
    logic [PW-1:0] m_pat = 8'h05;
    int            m_len = 3;
    bit            m_ov = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference: scan-order bit list, match where the last len bits since
    // the last restart equal the pattern (pattern bit 0 = newest bit).
    function automatic void model(input logic [DW-1:0] w,
                                  input logic [PW-1:0] p, input int l,
                                  input bit o, output logic [DW-1:0] mv,
                                  output int cnt);
        bit s[DW];
        int start;
        bit hit;
        mv = '0;
        cnt = 0;
        start = 0;
        for (int j = 0; j < DW; j++) s[j] = w[DW-1-j];
        for (int j = 0; j < DW; j++) begin
            hit = (j - start + 1 >= l);
            if (hit)
                for (int k = 0; k < l; k++)
                    if (s[j-k] != p[k]) hit = 1'b0;
            if (hit) begin
                mv[j] = 1'b1;
                if (cnt < (1 << CW) - 1) cnt++;
                if (!o) start = j + 1;
            end
        end
    endfunction

    function automatic void apply_cfg(input logic [PW-1:0] p, input int l,
                                      input bit o);
        if (l >= 1 && l <= PW) begin
            m_pat = p;
            m_len = l;
            m_ov = o;
        end
    endfunction

    function automatic void push(input logic [DW-1:0] w);
        exp_t e;
        e.w = w;
        model(w, m_pat, m_len, m_ov, e.mv, e.cnt);
        e.acc = cyc + 1;
        q.push_back(e);
    endfunction

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) timeout_fail("wait_ready");
    endtask

    task automatic set_cfg(input logic [PW-1:0] p, input int l, input bit o);
        logic [31:0] lv;
        lv = l;
        cfg_we = 1'b1;
        cfg_pattern = p;
        cfg_len = lv[LW-1:0];
        cfg_overlap = o;
    endtask

    task automatic drop_cfg();
        cfg_we = 1'b0;
        cfg_pattern = PW'($urandom);
        cfg_len = LW'($urandom);
        cfg_overlap = 1'($urandom);
    endtask

    task automatic send(input logic [DW-1:0] w, input bit cfg,
                        input logic [PW-1:0] p, input int l, input bit o);
        wait_ready();
        if (cfg) begin
            set_cfg(p, l, o);
            apply_cfg(p, l, o);
        end
        in_valid = 1'b1;
        in_data = w;
        push(w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = DW'($urandom);
        drop_cfg();
    endtask

    task automatic cfg_only(input logic [PW-1:0] p, input int l, input bit o);
        wait_ready();
        set_cfg(p, l, o);
        apply_cfg(p, l, o);
        @(posedge clk);
        #1;
        drop_cfg();
    endtask

    // Config strobe while a word is scanning; the model must not change.
    task automatic busy_cfg(input logic [PW-1:0] p, input int l, input bit o);
        @(negedge clk);
        set_cfg(p, l, o);
        @(posedge clk);
        #1;
        drop_cfg();
    endtask

    task automatic back2back(input logic [DW-1:0] w1, input logic [DW-1:0] w2);
        int a1;
        int a2;
        int g = 0;
        wait_ready();
        in_valid = 1'b1;
        in_data = w1;
        push(w1);
        a1 = cyc + 1;
        @(posedge clk);
        #1;
        in_data = w2;
        @(negedge clk);
        while (in_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) timeout_fail("b2b_ready");
        chk("b2b_ready_low_cycles", g, DW + 1);
        push(w2);
        a2 = cyc + 1;
        chk("b2b_gap", a2 - a1, DW + 2);
        @(posedge clk);
        #1;
        chk("b2b_count_clear", match_count, 0);
        chk("b2b_ready_after", in_ready, 0);
        in_valid = 1'b0;
        in_data = DW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bit_valid"}, bit_valid, 0);
        chk({tag, "_bit_out"}, bit_out, 0);
        chk({tag, "_match"}, match, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, match_count, 0);
    endtask

    // Monitor
    initial begin
        logic [DW-1:0] bits_seen;
        logic [DW-1:0] match_seen;
        int pos;
        exp_t e;
        bits_seen = '0;
        match_seen = '0;
        pos = 0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                pos = 0;
                bits_seen = '0;
                match_seen = '0;
                held = 0;
            end else begin
                chk("ready_vs_busy", in_ready, !busy);
                chk("busy_vs_phase", busy, bit_valid | done);
                if (!bit_valid) chk("match_outside_scan", match, 0);
                if (bit_valid) begin
                    if (pos < DW) begin
                        bits_seen[DW-1-pos] = bit_out;
                        match_seen[pos] = match;
                    end
                    pos++;
                end
                if (done) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done with empty queue");
                    end else begin
                        e = q.pop_front();
                        chk("scan_bits", bits_seen, e.w);
                        chk("match_pulses", match_seen, e.mv);
                        chk("match_count", match_count, e.cnt);
                        chk("done_latency", cyc - e.acc, DW);
                        chk("bit_cycles", pos, DW);
                        held = e.cnt;
                    end
                    pos = 0;
                    bits_seen = '0;
                    match_seen = '0;
                end
                if (!busy) chk("count_hold", match_count, held);
            end
        end
    end

    initial begin
        int g;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        aresetn = 1'b1;

        // default config, A5A5
        send(16'hA5A5, 1'b0, '0, 0, 1'b0);

        // overlap on / off
        send(16'hAAAA, 1'b1, 8'h05, 3, 1'b1);
        send(16'hAAAA, 1'b1, 8'h05, 3, 1'b0);

        // illegal lengths and busy writes are ignored
        cfg_only(8'h05, 3, 1'b1);
        cfg_only(8'hFF, 0, 1'b0);
        cfg_only(8'hFF, PW + 1, 1'b0);
        send(16'hA5A5, 1'b0, '0, 0, 1'b0);
        busy_cfg(8'hFF, 2, 1'b0);
        send(16'hA5A5, 1'b0, '0, 0, 1'b0);
        send(16'hCCCC, 1'b1, 8'h0C, 4, 1'b1);

        // len=1, counter saturation
        send(16'hFFFF, 1'b1, 8'h01, 1, 1'b1);

        // back-to-back words with in_valid held
        cfg_only(8'h05, 3, 1'b1);
        back2back(16'hA5A5, 16'h1234);

        // reset in the middle of a scan
        send(16'hCCCC, 1'b1, 8'h0C, 4, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midscan_reset");
        q.delete();
        m_pat = 8'h05;
        m_len = 3;
        m_ov = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        send(16'hA5A5, 1'b0, '0, 0, 1'b0);

        // randomized words and configs
        for (int i = 0; i < 40; i++) begin
            bit dc;
            dc = ($urandom % 3) == 0;
            send(DW'($urandom), dc, PW'($urandom), $urandom_range(0, 9),
                 1'($urandom));
            if ($urandom % 4 == 0)
                busy_cfg(PW'($urandom), $urandom_range(1, PW), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        g = 0;
        while (q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) timeout_fail("drain");
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
